// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types for the register-file write-port arbiter
package wb_port_arbiter_pkg;

   localparam int LU_ADDR_WIDTH = 5;
   localparam int LU_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_PIPE,
      GRANT_LU
   } wb_grant_e;

   typedef struct packed {
      logic [LU_ADDR_WIDTH-1:0] rd;
      logic [LU_DATA_WIDTH-1:0] data;
   } lu_wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - WB, LU and register-file write signals of the arbiter
interface wb_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BUF_DEPTH  = 2
);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic                  pipe_we_i;
   logic [ADDR_WIDTH-1:0] pipe_rd_i;
   logic [DATA_WIDTH-1:0] pipe_data_i;
   logic                  lu_valid_i;
   logic [ADDR_WIDTH-1:0] lu_rd_i;
   logic [DATA_WIDTH-1:0] lu_data_i;
   logic                  lu_ready_o;
   logic                  stall_o;
   logic                  rf_we_o;
   logic [ADDR_WIDTH-1:0] rf_waddr_o;
   logic [DATA_WIDTH-1:0] rf_wdata_o;
   logic [CNT_W-1:0]      buf_count_o;

   modport slave (
      input  pipe_we_i, pipe_rd_i, pipe_data_i, lu_valid_i, lu_rd_i, lu_data_i,
      output lu_ready_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, buf_count_o
   );

   modport master (
      output pipe_we_i, pipe_rd_i, pipe_data_i, lu_valid_i, lu_rd_i, lu_data_i,
      input  lu_ready_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, buf_count_o
   );
endinterface

// File: rtl/wb_port_arbiter_lu_fifo.sv
// rtl/wb_port_arbiter_lu_fifo.sv - synchronous FIFO holding pending LU results
module wb_lu_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between WB and LU results
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int BUF_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              rst_n,
   wb_port_arbiter_if.slave bus
);
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   wb_grant_e             grant;
   logic                  force_lu;
   logic                  pipe_req;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [EW-1:0]         head;
   logic [ADDR_WIDTH-1:0] head_rd;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CW-1:0]         count;
   logic [SW-1:0]         starve_cnt;
   logic                  lu_ready;
   logic                  rf_we;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;

   assign pipe_req  = bus.pipe_we_i && (bus.pipe_rd_i != '0);
   assign lu_ready  = rst_n && !fifo_full;
   assign fifo_push = bus.lu_valid_i && lu_ready;
   assign fifo_pop  = rst_n && (grant == GRANT_LU);
   assign {head_rd, head_data} = head;

   wb_lu_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({bus.lu_rd_i, bus.lu_data_i}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   always_comb begin
      grant    = GRANT_NONE;
      force_lu = 1'b0;
      if (fifo_empty) begin
         if (pipe_req) grant = GRANT_PIPE;
      end else if (!pipe_req) begin
         grant = GRANT_LU;
      end else if (starve_cnt == SW'(STARVE_LIMIT)) begin
         grant    = GRANT_LU;
         force_lu = 1'b1;
      end else begin
         grant = GRANT_PIPE;
      end
   end

   // Outputs stay quiet while reset is held, even if WB keeps requesting.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (rst_n) begin
         case (grant)
            GRANT_PIPE: begin
               rf_we    = 1'b1;
               rf_waddr = bus.pipe_rd_i;
               rf_wdata = bus.pipe_data_i;
            end
            GRANT_LU: begin
               rf_we    = (head_rd != '0);
               rf_waddr = head_rd;
               rf_wdata = head_data;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant == GRANT_LU || fifo_empty) begin
         starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   assign bus.lu_ready_o  = lu_ready;
   assign bus.stall_o     = rst_n && force_lu;
   assign bus.rf_we_o     = rf_we;
   assign bus.rf_waddr_o  = rf_waddr;
   assign bus.rf_wdata_o  = rf_wdata;
   assign bus.buf_count_o = count;

endmodule
